seg7_shift_out: RTL and testbench

Serial output stage downstream of the seven-segment digit counter/decoder. Takes the 7-bit segment pattern (plus decimal point) and shifts it MSB-first into an external 74HC595-style shift register via data, shift-clock and latch pins, so that multiple digits or pins can be driven from only three outputs. It is one frame buffer deep: updates that arrive mid-frame are held, and the newest one wins.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_shift_tick.sv | 25 ++
 rtl/seg7_shift_out.sv | 131 +++++++++++++
 tb/tb_seg7_shift_out.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and sizes for the seven-segment serial output stage.
package seg7_pkg;

    localparam int FRAME_BITS = 8;
    localparam int SEG_WIDTH  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

endpackage

// File: rtl/seg7_shift_tick.sv
// Phase counter: terminal-count pulse every CLK_DIV cycles, restarted on every state change.
module seg7_shift_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tc
);
    localparam int            PW   = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (reset || clear || (phase == LAST)) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    assign tc = (phase == LAST);

endmodule

// File: rtl/seg7_shift_out.sv
// Shifts {dp, segments} MSB-first into a 74HC595-style register, then pulses the latch.
// One frame of buffering: input arriving mid-frame is held and the newest one wins.
module seg7_shift_out
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [SEG_WIDTH-1:0] in_segments,
    input  logic                 in_dp,
    output logic                 sr_data,
    output logic                 sr_clk,
    output logic                 sr_latch,
    output logic                 busy,
    output logic                 frame_done
);
    // state    | meaning
    // IDLE     | no frame in flight
    // SHIFT_LO | sr_clk low, current bit presented on sr_data
    // SHIFT_HI | sr_clk high, external register samples sr_data
    // LATCH    | sr_latch high, storage register updates

    state_t                state, state_n;
    logic [2:0]            bit_idx, bit_idx_n;
    logic [FRAME_BITS-1:0] frame_q, frame_n;
    logic [FRAME_BITS-1:0] pend_data, pend_data_n;
    logic [FRAME_BITS-1:0] incoming, start_byte;
    logic                  pend_valid, pend_valid_n;
    logic                  sr_data_n;
    logic                  start;
    logic                  tc;
    logic                  latch_exit;

    assign incoming   = {in_dp, in_segments};
    assign latch_exit = (state == LATCH) && tc;

    seg7_shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_n != state),
        .tc    (tc)
    );

    always_comb begin
        state_n      = state;
        bit_idx_n    = bit_idx;
        frame_n      = frame_q;
        pend_data_n  = pend_data;
        pend_valid_n = pend_valid;
        sr_data_n    = sr_data;
        start        = 1'b0;
        start_byte   = incoming;

        case (state)
            IDLE: begin
                if (in_valid) start = 1'b1;
            end
            SHIFT_LO: begin
                if (tc) state_n = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (tc) begin
                    if (bit_idx == 3'd0) begin
                        state_n = LATCH;
                    end else begin
                        state_n   = SHIFT_LO;
                        bit_idx_n = bit_idx - 3'd1;
                        sr_data_n = frame_q[bit_idx_n];
                    end
                end
            end
            LATCH: begin
                if (tc) begin
                    // A strobe on the exit cycle is newer than anything pending.
                    if (in_valid) begin
                        start        = 1'b1;
                        pend_valid_n = 1'b0;
                    end else if (pend_valid) begin
                        start        = 1'b1;
                        start_byte   = pend_data;
                        pend_valid_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (in_valid && (state != IDLE) && !latch_exit) begin
            pend_data_n  = incoming;
            pend_valid_n = 1'b1;
        end

        if (start) begin
            state_n   = SHIFT_LO;
            frame_n   = start_byte;
            bit_idx_n = 3'd7;
            sr_data_n = start_byte[FRAME_BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            frame_q    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            sr_data    <= 1'b0;
            sr_clk     <= 1'b0;
            sr_latch   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            frame_q    <= frame_n;
            pend_data  <= pend_data_n;
            pend_valid <= pend_valid_n;
            sr_data    <= sr_data_n;
            sr_clk     <= (state_n == SHIFT_HI);
            sr_latch   <= (state_n == LATCH);
            busy       <= (state_n != IDLE);
            frame_done <= latch_exit;
        end
    end

endmodule

// File: tb/tb_seg7_shift_out.sv
// Self-checking bench for seg7_shift_out: per-cycle compare against a frame-schedule model.
module tb_seg7_shift_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_vld, a_dp;
    logic [6:0] a_seg;
    logic       a_data, a_sclk, a_latch, a_busy, a_done;
    logic       b_rst, b_vld, b_dp;
    logic [6:0] b_seg;
    logic       b_data, b_sclk, b_latch, b_busy, b_done;

    seg7_shift_out #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(a_rst), .in_valid(a_vld), .in_segments(a_seg), .in_dp(a_dp),
        .sr_data(a_data), .sr_clk(a_sclk), .sr_latch(a_latch), .busy(a_busy), .frame_done(a_done)
    );

    seg7_shift_out #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(b_rst), .in_valid(b_vld), .in_segments(b_seg), .in_dp(b_dp),
        .sr_data(b_data), .sr_clk(b_sclk), .sr_latch(b_latch), .busy(b_busy), .frame_done(b_done)
    );

    // observed / expected vector order: {sr_data, sr_clk, sr_latch, busy, frame_done}
    bit         use_b = 1'b0;
    logic [4:0] obs, expv;
    assign obs = use_b ? {b_data, b_sclk, b_latch, b_busy, b_done}
                       : {a_data, a_sclk, a_latch, a_busy, a_done};

    int checks = 0;
    int errors = 0;

    // Reference model: a schedule of frames, each 17*D cycles from its start edge.
    int         m_d = 2;
    int         t = 0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00, m_pend_byte = 8'h00;
    bit         m_active = 0, m_pend = 0, m_done = 0;
    logic       m_last = 1'b0;

    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    logic       prev_clk = 1'b0;

    function automatic void model_edge(input bit vld, input logic [7:0] b, input bit rst);
        t++;
        if (rst) begin
            m_active = 0; m_pend = 0; m_last = 1'b0; m_done = 0;
            return;
        end
        m_done = m_active && (t == m_start + 17 * m_d);
        if (m_done) begin
            m_active = 0;
            m_last   = m_byte[0];
        end
        if (vld) begin
            if (!m_active) begin
                m_active = 1; m_start = t; m_byte = b; m_pend = 0;
            end else begin
                m_pend = 1; m_pend_byte = b;
            end
        end else if (!m_active && m_pend) begin
            m_active = 1; m_start = t; m_byte = m_pend_byte; m_pend = 0;
        end
    endfunction

    function automatic logic [4:0] model_out();
        int   o;
        logic d, c, l;
        if (!m_active) return {m_last, 1'b0, 1'b0, 1'b0, m_done};
        o = t - m_start;
        c = (o < 16 * m_d) && (((o / m_d) % 2) == 1);
        l = (o >= 16 * m_d);
        d = (o < 16 * m_d) ? m_byte[7 - o / (2 * m_d)] : m_byte[0];
        return {d, c, l, 1'b1, m_done};
    endfunction

    // One clock: drive inputs, advance the model at the edge, sample at the falling edge.
    task automatic step(input bit vld, input logic [7:0] byte_in, input bit rst);
        if (use_b) begin
            b_vld = vld; b_seg = byte_in[6:0]; b_dp = byte_in[7]; b_rst = rst;
        end else begin
            a_vld = vld; a_seg = byte_in[6:0]; a_dp = byte_in[7]; a_rst = rst;
        end
        @(posedge clk);
        model_edge(vld, byte_in, rst);
        @(negedge clk);
        a_vld = 1'b0; a_rst = 1'b0; b_vld = 1'b0; b_rst = 1'b0;
        expv = model_out();
        if (!rst) begin
            if (obs[3] && !prev_clk) rx_sh = {rx_sh[6:0], obs[4]};
            if (obs[0]) rx_q.push_back(rx_sh);
        end
        prev_clk = obs[3];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b want 00000", i, obs);
            end
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL idle_hold cyc%0d: got %b want 00000", i, obs);
            end
        end
    endtask

    task automatic test_single_a5();
        int latch_cnt = 0;
        rx_q.delete();
        for (int i = 0; i < 42; i++) begin
            step(i == 0, 8'hA5, 1'b0);
            if (obs[2]) latch_cnt++;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single_a5 cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (latch_cnt != 2) begin
            errors++;
            $display("FAIL single_a5 latch_len: got %0d want 2", latch_cnt);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_a5 rx: got n=%0d first=%h want n=1 a5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_newest_wins();
        logic [7:0] first;
        int done_cnt = 0;
        first = 8'($urandom);
        rx_q.delete();
        for (int i = 0; i < 80; i++) begin
            if (i == 0)       step(1'b1, first, 1'b0);
            else if (i == 10) step(1'b1, 8'h3F, 1'b0);
            else if (i == 20) step(1'b1, 8'h06, 1'b0);
            else              step(1'b0, 8'h00, 1'b0);
            if (obs[0]) done_cnt++;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL newest_wins cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (done_cnt != 2) begin
            errors++;
            $display("FAIL newest_wins done_count: got %0d want 2", done_cnt);
        end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== first || rx_q[1] !== 8'h06) begin
            errors++;
            $display("FAIL newest_wins rx: got n=%0d want %h,06", rx_q.size(), first);
        end
    endtask

    task automatic test_latch_exit();
        logic [7:0] first;
        first = 8'($urandom);
        rx_q.delete();
        for (int i = 0; i < 80; i++) begin
            if (i == 0)       step(1'b1, first, 1'b0);
            else if (i == 10) step(1'b1, 8'h4F, 1'b0);
            else if (i == 34) step(1'b1, 8'h5B, 1'b0);
            else              step(1'b0, 8'h00, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL latch_exit cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== first || rx_q[1] !== 8'h5B) begin
            errors++;
            $display("FAIL latch_exit rx: got n=%0d want %h,5b only", rx_q.size(), first);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] first, second;
        int latch_cnt = 0;
        first  = 8'($urandom);
        second = 8'($urandom);
        rx_q.delete();
        for (int i = 0; i < 12; i++) begin
            step(i == 0, first, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid pre cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid abort: got %b want 00000", obs);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (obs[2]) latch_cnt++;
        end
        checks++;
        if (latch_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid stray_latch: got %0d want 0", latch_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            step(i == 0, second, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid post cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== second) begin
            errors++;
            $display("FAIL reset_mid rx: got n=%0d want 1 frame %h", rx_q.size(), second);
        end
    endtask

    task automatic test_random();
        bit         v;
        logic [7:0] b;
        for (int i = 0; i < 840; i++) begin
            v = (i < 800) && ($urandom_range(0, 24) == 0);
            b = 8'($urandom);
            step(v, b, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_div1();
        int busy_cnt = 0;
        use_b = 1'b1;
        m_d   = 1;
        prev_clk = 1'b0;
        rx_q.delete();
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 25; i++) begin
            step(i == 0, 8'hFF, 1'b0);
            if (obs[1]) busy_cnt++;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL div1 cyc%0d: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (busy_cnt != 17) begin
            errors++;
            $display("FAIL div1 frame_len: got %0d want 17", busy_cnt);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hFF) begin
            errors++;
            $display("FAIL div1 rx: got n=%0d want 1 frame ff", rx_q.size());
        end
    endtask

    initial begin
        a_rst = 1'b1; a_vld = 1'b0; a_seg = 7'd0; a_dp = 1'b0;
        b_rst = 1'b1; b_vld = 1'b0; b_seg = 7'd0; b_dp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        test_reset();
        test_idle_hold();
        test_single_a5();
        test_newest_wins();
        test_latch_exit();
        test_reset_mid();
        test_random();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
